// File: rtl/hps_reset_pkg.sv
// Shared types and constants for the HPS reset requester.
package hps_reset_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        HOLDOFF
    } state_t;

    typedef enum logic [1:0] {
        REQ_COLD,
        REQ_WARM,
        REQ_DEBUG
    } req_kind_t;

    // Bit positions inside stm_hwevents_o; the first three also index the request vectors.
    localparam int EV_COLD    = 0;
    localparam int EV_WARM    = 1;
    localparam int EV_DEBUG   = 2;
    localparam int EV_H2F_REL = 3;

    localparam int STM_WIDTH  = 28;

    // One-hot mask of a request kind, ordered {debug, warm, cold}.
    function automatic logic [2:0] kind_mask(input req_kind_t kind);
        logic [2:0] mask;
        mask = '0;
        case (kind)
            REQ_COLD:  mask[EV_COLD]  = 1'b1;
            REQ_WARM:  mask[EV_WARM]  = 1'b1;
            REQ_DEBUG: mask[EV_DEBUG] = 1'b1;
            default:   mask = '0;
        endcase
        return mask;
    endfunction

    // Number of set bits in a 3-bit vector.
    function automatic logic [1:0] count3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/hps_reset_requester_reset_sync.sv
// Async-assert / sync-deassert reset synchronizer of configurable depth.
module reset_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic arst_n,
    output logic sync_n
);

    logic [STAGES-1:0] stage_reg;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                // First stage captures a constant 1 once the reset is released.
                always_ff @(posedge clk or negedge arst_n) begin
                    if (!arst_n) stage_reg[gi] <= 1'b0;
                    else         stage_reg[gi] <= 1'b1;
                end
            end else begin : g_rest
                // Later stages shift the release along the chain.
                always_ff @(posedge clk or negedge arst_n) begin
                    if (!arst_n) stage_reg[gi] <= 1'b0;
                    else         stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

    assign sync_n = stage_reg[STAGES-1];

endmodule

// File: rtl/hps_reset_requester.sv
// Turns fabric request edges into timed active-low HPS reset requests,
// enforces a holdoff between requests and synchronizes the HPS h2f reset.
module hps_reset_requester
    import hps_reset_pkg::*;
#(
    parameter int PULSE_CYCLES   = 16,
    parameter int HOLDOFF_CYCLES = 1024,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic                 cold_req_i,
    input  logic                 warm_req_i,
    input  logic                 debug_req_i,
    input  logic                 h2f_reset_n_i,
    output logic                 f2h_cold_reset_req_n_o,
    output logic                 f2h_warm_reset_req_n_o,
    output logic                 f2h_debug_reset_req_n_o,
    output logic                 fabric_reset_n_o,
    output logic                 busy_o,
    output logic [7:0]           drop_cnt_o,
    output logic [STM_WIDTH-1:0] stm_hwevents_o
);

    localparam logic [15:0] PULSE_LOAD = 16'(PULSE_CYCLES - 1);
    localparam logic [15:0] HOLD_LOAD  = 16'(HOLDOFF_CYCLES - 1);

    state_t      state_reg, state_next;
    req_kind_t   kind_reg, kind_next;
    logic [15:0] pulse_cnt_reg, pulse_cnt_next;
    logic [15:0] hold_cnt_reg, hold_cnt_next;
    logic [2:0]  req_n_reg, req_n_next;
    logic [2:0]  ev_reg, ev_next;
    logic [2:0]  prev_reg;
    logic [7:0]  drop_reg, drop_next;
    logic [1:0]  drop_inc;
    logic [8:0]  drop_sum;
    logic        sync_prev_reg;

    logic [2:0]  req_in;
    logic [2:0]  rise;
    logic        h2f_sync_n;
    logic        sync_arst_n;

    assign req_in = {debug_req_i, warm_req_i, cold_req_i};
    assign rise   = req_in & ~prev_reg;

    // Either reset source pulls the fabric reset low immediately.
    assign sync_arst_n = reset_reset_n & h2f_reset_n_i;

    reset_sync #(
        .STAGES (SYNC_STAGES)
    ) u_reset_sync (
        .clk    (clk_clk),
        .arst_n (sync_arst_n),
        .sync_n (h2f_sync_n)
    );

    // State, counters, registered outputs and edge history.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_reg     <= IDLE;
            kind_reg      <= REQ_COLD;
            pulse_cnt_reg <= '0;
            hold_cnt_reg  <= '0;
            req_n_reg     <= 3'b111;
            ev_reg        <= '0;
            prev_reg      <= 3'b111;
            drop_reg      <= '0;
            sync_prev_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            kind_reg      <= kind_next;
            pulse_cnt_reg <= pulse_cnt_next;
            hold_cnt_reg  <= hold_cnt_next;
            req_n_reg     <= req_n_next;
            ev_reg        <= ev_next;
            prev_reg      <= req_in;
            drop_reg      <= drop_next;
            sync_prev_reg <= h2f_sync_n;
        end
    end

    // Next-state logic: accept one edge in IDLE, time the pulse, then the holdoff.
    always_comb begin
        state_next     = state_reg;
        kind_next      = kind_reg;
        pulse_cnt_next = pulse_cnt_reg;
        hold_cnt_next  = hold_cnt_reg;
        req_n_next     = req_n_reg;
        ev_next        = '0;
        drop_inc       = '0;

        case (state_reg)
            IDLE: begin
                if (rise != 3'b000) begin
                    if (rise[EV_COLD]) begin
                        kind_next = REQ_COLD;
                        drop_inc  = count3({rise[EV_DEBUG], rise[EV_WARM], 1'b0});
                    end else if (rise[EV_WARM]) begin
                        kind_next = REQ_WARM;
                        drop_inc  = count3({rise[EV_DEBUG], 2'b00});
                    end else begin
                        kind_next = REQ_DEBUG;
                    end
                    state_next     = ASSERT;
                    pulse_cnt_next = PULSE_LOAD;
                    req_n_next     = ~kind_mask(kind_next);
                    ev_next        = kind_mask(kind_next);
                end
            end
            ASSERT: begin
                drop_inc = count3(rise);
                if (pulse_cnt_reg == 16'd0) begin
                    state_next    = HOLDOFF;
                    req_n_next    = 3'b111;
                    hold_cnt_next = HOLD_LOAD;
                end else begin
                    pulse_cnt_next = pulse_cnt_reg - 16'd1;
                    req_n_next     = ~kind_mask(kind_reg);
                end
            end
            HOLDOFF: begin
                drop_inc = count3(rise);
                // Holdoff only counts once the HPS has come back out of reset.
                if (!h2f_sync_n) begin
                    hold_cnt_next = HOLD_LOAD;
                end else if (hold_cnt_reg == 16'd0) begin
                    state_next = IDLE;
                end else begin
                    hold_cnt_next = hold_cnt_reg - 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
                req_n_next = 3'b111;
            end
        endcase
    end

    // Saturating drop counter update.
    always_comb begin
        drop_sum  = {1'b0, drop_reg} + {7'd0, drop_inc};
        drop_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    // STM event vector: request pulses plus the synchronized h2f release edge.
    always_comb begin
        stm_hwevents_o             = '0;
        stm_hwevents_o[EV_COLD]    = ev_reg[EV_COLD];
        stm_hwevents_o[EV_WARM]    = ev_reg[EV_WARM];
        stm_hwevents_o[EV_DEBUG]   = ev_reg[EV_DEBUG];
        stm_hwevents_o[EV_H2F_REL] = h2f_sync_n & ~sync_prev_reg;
    end

    assign f2h_cold_reset_req_n_o  = req_n_reg[EV_COLD];
    assign f2h_warm_reset_req_n_o  = req_n_reg[EV_WARM];
    assign f2h_debug_reset_req_n_o = req_n_reg[EV_DEBUG];
    assign fabric_reset_n_o        = h2f_sync_n;
    assign busy_o                  = (state_reg != IDLE);
    assign drop_cnt_o              = drop_reg;

endmodule
